// File: rtl/cpu_types_pkg.sv
// Types shared by the CPU memory path: RAM handshake status, arbiter states
// and the machine word.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } arb_state_t;

    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants taken while an instruction fetch waits.
// Clear wins over increment; the count stops at LIMIT and never wraps.
module arb_starve_cnt
    import cpu_types_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < LIMIT_C)) begin
            cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port RAM between instruction fetch and data access.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_bus_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    arb_state_t state_q;
    arb_state_t state_d;
    ramstate_t  ram_st;
    logic       d_req;
    logic       ram_done;
    logic       at_limit;
    logic       starve_inc;
    logic       starve_clr;

    assign ram_st   = ramstate_t'(ramstate);
    assign ram_done = (ram_st == ACCESS);
    assign d_req    = dREN | dWEN;

    always_comb begin
        state_d    = state_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && !(iREN && at_limit)) begin
                    state_d    = DGNT;
                    starve_inc = iREN;
                end else if (iREN) begin
                    state_d    = IGNT;
                    starve_clr = 1'b1;
                end
                if (!iREN) begin
                    starve_clr = 1'b1;
                end
            end
            IGNT: begin
                if (ram_done || !iREN) begin
                    state_d = IDLE;
                end
            end
            DGNT: begin
                if (ram_done || !d_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk_i      (CLK),
        .rst_ni     (nRST),
        .inc_i      (starve_inc),
        .clr_i      (starve_clr),
        .at_limit_o (at_limit)
    );

    // Completion is reported for ACCESS even if the request drops in that same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state_q)
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = !ram_done;
                if (ram_done) begin
                    iload = ramload;
                end
            end
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !ram_done;
                if (ram_done && dREN && !dWEN) begin
                    dload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// run against a bus-ownership reference model.
module tb_mem_bus_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIM   = 4;
    localparam int          LIM_I = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] iload;
    logic          iwait;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic [DW-1:0] dload;
    logic          dwait;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic [1:0]    ramstate;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    function automatic logic [3:0] ctl();
        return {ramREN, ramWEN, iwait, dwait};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drop_all();
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        ramstate = 2'd0;
    endtask

    task automatic idle_ticks();
        drop_all();
        tick();
        tick();
    endtask

    task automatic test_reset();
        nRST    = 1'b0;
        drop_all();
        iaddr   = 32'h0000_0abc;
        daddr   = 32'h0000_0def;
        dstore  = 32'h1111_2222;
        ramload = 32'h3333_4444;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected %b", ctl(), 4'b0011);
        end
        n_checks++;
        if ({ramaddr, ramstore, iload, dload} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {ramaddr, ramstore, iload, dload});
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        tick();
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b0011) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected %b", ctl(), 4'b0011);
        end
        tick();
    endtask

    task automatic test_reset_mid_dgnt();
        dWEN     = 1'b1;
        daddr    = 32'h40;
        dstore   = 32'h55;
        ramstate = 2'd1;
        tick();
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b0111 || ramaddr !== 32'h40) begin
            n_fail++;
            $display("FAIL mid_dgnt_grant: got ctl %b addr %h expected ctl 0111 addr 40", ctl(), ramaddr);
        end
        #2;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (ctl() !== 4'b0011 || ramaddr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got ctl %b addr %h expected ctl 0011 addr 0", ctl(), ramaddr);
        end
        @(posedge CLK);
        #1;
        drop_all();
        ramstate = 2'd2;
        nRST     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n_checks++;
            if (ctl() !== 4'b0011) begin
                n_fail++;
                $display("FAIL no_spurious_done%0d: got %b expected %b", k, ctl(), 4'b0011);
            end
            tick();
        end
        idle_ticks();
    endtask

    task automatic test_single_fetch();
        iREN     = 1'b1;
        iaddr    = 32'h100;
        ramstate = 2'd2;
        ramload  = 32'h2001_0004;
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b0011) begin
            n_fail++;
            $display("FAIL fetch_arb: got %b expected %b", ctl(), 4'b0011);
        end
        tick();
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b1001) begin
            n_fail++;
            $display("FAIL fetch_ctl: got %b expected %b", ctl(), 4'b1001);
        end
        n_checks++;
        if (iload !== 32'h2001_0004) begin
            n_fail++;
            $display("FAIL fetch_iload: got %h expected %h", iload, 32'h2001_0004);
        end
        n_checks++;
        if (ramaddr !== 32'h100) begin
            n_fail++;
            $display("FAIL fetch_addr: got %h expected %h", ramaddr, 32'h100);
        end
        tick();
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b0011 || iload !== 32'h0) begin
            n_fail++;
            $display("FAIL fetch_turnaround: got ctl %b iload %h expected ctl 0011 iload 0", ctl(), iload);
        end
        idle_ticks();
    endtask

    task automatic test_contention();
        iREN     = 1'b1;
        dREN     = 1'b1;
        iaddr    = 32'h300;
        daddr    = 32'h200;
        ramstate = 2'd2;
        ramload  = 32'hA5A5_0001;
        tick();
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b1010 || ramaddr !== 32'h200 || dload !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL contention_data_first: got ctl %b addr %h dload %h expected ctl 1010 addr 200 dload a5a50001",
                     ctl(), ramaddr, dload);
        end
        tick();
        dREN = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b0011) begin
            n_fail++;
            $display("FAIL contention_turnaround: got %b expected %b", ctl(), 4'b0011);
        end
        tick();
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b1001 || ramaddr !== 32'h300 || iload !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL contention_fetch_next: got ctl %b addr %h iload %h expected ctl 1001 addr 300 iload a5a50001",
                     ctl(), ramaddr, iload);
        end
        idle_ticks();
    endtask

    task automatic test_starvation();
        int dcount = 0;
        bit got_i  = 1'b0;
        iREN     = 1'b1;
        dWEN     = 1'b1;
        iaddr    = 32'h500;
        daddr    = 32'h600;
        dstore   = 32'h1234;
        ramstate = 2'd2;
        ramload  = 32'h7777_0000;
        for (int c = 0; c < 40 && !got_i; c++) begin
            @(negedge CLK);
            if (!dwait) dcount++;
            if (!iwait) got_i = 1'b1;
            tick();
        end
        n_checks++;
        if (!got_i) begin
            n_fail++;
            $display("FAIL starve_timeout: got no fetch grant expected one within 40 cycles");
        end
        n_checks++;
        if (dcount !== LIM_I) begin
            n_fail++;
            $display("FAIL starve_data_count: got %0d expected %0d", dcount, LIM_I);
        end
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b0011) begin
            n_fail++;
            $display("FAIL starve_turnaround: got %b expected %b", ctl(), 4'b0011);
        end
        tick();
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b0110 || ramaddr !== 32'h600 || ramstore !== 32'h1234) begin
            n_fail++;
            $display("FAIL starve_data_resumes: got ctl %b addr %h store %h expected ctl 0110 addr 600 store 1234",
                     ctl(), ramaddr, ramstore);
        end
        idle_ticks();
    endtask

    task automatic test_abort();
        iREN     = 1'b1;
        iaddr    = 32'h180;
        ramstate = 2'd1;
        tick();
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b1011) begin
            n_fail++;
            $display("FAIL abort_grant: got %b expected %b", ctl(), 4'b1011);
        end
        tick();
        iREN = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b1011) begin
            n_fail++;
            $display("FAIL abort_drop_cycle: got %b expected %b", ctl(), 4'b1011);
        end
        tick();
        dREN  = 1'b1;
        daddr = 32'h44;
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b0011) begin
            n_fail++;
            $display("FAIL abort_idle: got %b expected %b", ctl(), 4'b0011);
        end
        tick();
        ramstate = 2'd2;
        ramload  = 32'h0BAD_F00D;
        @(negedge CLK);
        n_checks++;
        if (ctl() !== 4'b1010 || ramaddr !== 32'h44 || dload !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL abort_next_data: got ctl %b addr %h dload %h expected ctl 1010 addr 44 dload 0badf00d",
                     ctl(), ramaddr, dload);
        end
        idle_ticks();
    endtask

    task automatic test_error_retry();
        logic [1:0]  seq    [3] = '{2'd3, 2'd3, 2'd2};
        logic        exp_dw [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] exp_ld [3] = '{32'h0, 32'h0, 32'hDEAD_BEEF};
        dREN     = 1'b1;
        daddr    = 32'h88;
        ramstate = 2'd3;
        ramload  = 32'hDEAD_BEEF;
        tick();
        for (int k = 0; k < 3; k++) begin
            ramstate = seq[k];
            iaddr    = $urandom;
            @(negedge CLK);
            n_checks++;
            if (dwait !== exp_dw[k]) begin
                n_fail++;
                $display("FAIL retry_dwait%0d: got %b expected %b", k, dwait, exp_dw[k]);
            end
            n_checks++;
            if (dload !== exp_ld[k]) begin
                n_fail++;
                $display("FAIL retry_dload%0d: got %h expected %h", k, dload, exp_ld[k]);
            end
            n_checks++;
            if (ramaddr !== 32'h88 || ramREN !== 1'b1) begin
                n_fail++;
                $display("FAIL retry_addr%0d: got addr %h ren %b expected addr 88 ren 1", k, ramaddr, ramREN);
            end
            tick();
        end
        idle_ticks();
    endtask

    // Reference: who owns the bus this cycle, plus how many data grants the
    // waiting fetch has already conceded.
    task automatic test_random();
        int owner  = 0;
        int streak = 0;
        logic        acc;
        logic [131:0] exp_v;
        logic [131:0] act_v;
        idle_ticks();
        for (int c = 0; c < 600; c++) begin
            iREN     = ($urandom_range(0, 3) != 0);
            dREN     = 1'($urandom_range(0, 1));
            dWEN     = ($urandom_range(0, 2) == 0);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'($urandom_range(0, 3));
            @(negedge CLK);
            acc   = (ramstate == 2'd2);
            exp_v = {4'b0011, 128'h0};
            if (owner == 1) begin
                exp_v = {1'b1, 1'b0, ~acc, 1'b1, iaddr, 32'h0, acc ? ramload : 32'h0, 32'h0};
            end else if (owner == 2) begin
                exp_v = {dREN & ~dWEN, dWEN, 1'b1, ~acc, daddr, dstore, 32'h0,
                         (acc && dREN && !dWEN) ? ramload : 32'h0};
            end
            act_v = {ramREN, ramWEN, iwait, dwait, ramaddr, ramstore, iload, dload};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h (owner %0d streak %0d)",
                         c, act_v, exp_v, owner, streak);
            end
            @(posedge CLK);
            if (owner == 0) begin
                if ((dREN || dWEN) && !(iREN && streak >= LIM_I)) begin
                    owner  = 2;
                    streak = iREN ? ((streak < LIM_I) ? streak + 1 : streak) : 0;
                end else if (iREN) begin
                    owner  = 1;
                    streak = 0;
                end else begin
                    streak = 0;
                end
            end else if (owner == 1) begin
                if (acc || !iREN) owner = 0;
            end else begin
                if (acc || !(dREN || dWEN)) owner = 0;
            end
            #1;
        end
        idle_ticks();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_reset_mid_dgnt();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_abort();
        test_error_retry();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences the shared single-port RAM between the instruction-fetch path (icache side) and the data-memory path (dcache side).
- Sits between the caches and the RAM model, below the pipeline's ihit/dhit stall logic.
- Data requests have priority by default.
- A bounded starvation counter guarantees instruction fetch forward progress while a store/load-heavy loop runs.

Parameters:
- ADDR_W, 32, address width of both request ports and the RAM port.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants tolerated while an instruction request waits; the next arbitration then goes to instruction. Legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request; held until iwait=0.
- iaddr  in  ADDR_W  instruction address.
- iload  out  DATA_W  instruction read data; valid when iwait=0.
- iwait  out  1  instruction port stall; 0 for exactly the completion cycle.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are high.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dload  out  DATA_W  data read data; valid when dwait=0.
- dwait  out  1  data port stall.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Reset: asynchronous on nRST low.
  - State goes to IDLE and the starvation counter to 0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait=1, dwait=1, iload=0, dload=0.
  - Reset mid-transaction abandons the access immediately. No completion pulse is produced.
- States: IDLE, IGNT, DGNT. State is registered; all outputs are combinational from state and inputs.
- IDLE:
  - RAM strobes are 0 and ramaddr/ramstore are 0. Both waits are 1.
  - Next state:
    - if (dREN|dWEN) and not (iREN and cnt==STARVE_LIMIT): DGNT.
    - else if iREN: IGNT.
    - else: IDLE.
- IGNT:
  - ramREN=1, ramWEN=0, ramaddr=iaddr.
  - iwait = (ramstate!=ACCESS). iload=ramload when ramstate==ACCESS, else 0. dwait=1.
  - On ACCESS, go to IDLE next cycle.
  - If iREN drops before ACCESS (abort, e.g. branch redirect), go to IDLE next cycle with no completion.
- DGNT:
  - ramWEN=dWEN; ramREN=dREN&~dWEN; ramaddr=daddr; ramstore=dstore.
  - dwait = (ramstate!=ACCESS). dload=ramload on a read ACCESS, else 0. iwait=1.
  - On ACCESS, go to IDLE.
  - If both dREN and dWEN drop, abort to IDLE.
- ERROR or BUSY: stay in the grant state with signals held. The RAM retries; there is no timeout.
- Latency:
  - Minimum 2 cycles per access: 1 arbitration cycle in IDLE, then completion when ramstate is ACCESS in the first grant cycle.
  - One IDLE turnaround cycle is always inserted between back-to-back accesses. This is a fixed property; it keeps grants registered.
- Starvation counter (cnt, 4 bits, saturating at STARVE_LIMIT):
  - Increments on each DGNT entry taken while iREN=1.
  - Clears on IGNT entry or whenever iREN=0 in IDLE.
  - Never wraps.
- Simultaneous requests in IDLE with cnt<STARVE_LIMIT: data wins.
- A request change in the same cycle as ACCESS still completes that access.
- Request inputs are sampled only in IDLE and in the current grant state. The non-granted port's address/data changes are ignored.

Decomposition:
- Shared package (cpu_types_pkg):
  - ramstate_t enum {FREE, BUSY, ACCESS, ERROR}.
  - arb_state_t enum {IDLE, IGNT, DGNT}.
  - word_t from the existing package.
- One sub-module is natural: arb_starve_cnt (saturating counter with inc/clr inputs and an at_limit output).
- The mux and FSM stay in the top.

Test Plan:
- Reset mid-DGNT: dWEN=1, daddr=0x40, ramstate=BUSY, then nRST=0 asynchronously -> ramWEN=0, dwait=1, state IDLE with no clock edge; after release, no spurious completion.
- Single fetch: iREN=1, iaddr=0x100, RAM ACCESS on the first grant cycle with ramload=0x2001_0004 -> iwait=0 at cycle 1 with iload=0x2001_0004, ramREN=1, ramaddr=0x100; cycle 2 is IDLE.
- Contention: iREN=dREN=1 together, daddr=0x200 -> DGNT first, ramaddr=0x200, dwait=0 on ACCESS; then IDLE, then IGNT serving iaddr.
- Starvation: STARVE_LIMIT=4, dWEN and iREN held continuously, RAM always ACCESS -> exactly 4 data writes complete, then the 5th grant is IGNT; cnt then clears and data resumes.
- Abort: iREN=1, ramstate=BUSY for 3 cycles, iREN drops in cycle 2 -> ramREN=0 from cycle 3, iwait never 0, next dREN is granted normally.
- Error retry: dREN=1, ramstate sequence ERROR,ERROR,ACCESS with ramload=0xDEAD_BEEF -> dwait=1,1,0; dload=0xDEAD_BEEF on the third grant cycle; ramaddr held stable throughout.
